// File: rtl/fir_mul_pkg.sv
// fir_mul_pkg: shared defaults, width functions and parameter legality checks for fir_mul_pipe
package fir_mul_pkg;
   localparam int A_W_DEF       = 16;
   localparam int B_W_DEF       = 11;
   localparam int OUT_W_DEF     = 27;
   localparam int NUM_STAGE_DEF = 2;
   localparam int SHIFT_DEF     = 0;
   localparam int GUARD_DEF     = 4;
   function automatic int p_w(int a_w, int b_w);
      return a_w + b_w;
   endfunction
   function automatic int acc_w(int a_w, int b_w, int guard);
      return a_w + b_w + guard;
   endfunction
   function automatic bit stage_ok(int n);
      return n >= 1 && n <= 4;
   endfunction
   function automatic bit shift_ok(int s, int a_w, int b_w);
      return s >= 0 && s <= a_w + b_w - 1;
   endfunction
endpackage

// File: rtl/fir_mul_round_sat.sv
// fir_mul_round_sat: round-half-up arithmetic right shift of the accumulator, then clamp to signed OUT_W
module fir_mul_round_sat
   import fir_mul_pkg::*;
#(
   parameter int ACC_W = acc_w(A_W_DEF, B_W_DEF, GUARD_DEF),
   parameter int SHIFT = SHIFT_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic signed [ACC_W-1:0] acc_i,
   output logic        [OUT_W-1:0] dout_o,
   output logic                    sat_o
);
   localparam int W = (ACC_W + 1 > OUT_W ? ACC_W + 1 : OUT_W) + 1;
   localparam logic signed [W-1:0] RND = SHIFT == 0 ? '0 : W'(1) << (SHIFT > 0 ? SHIFT - 1 : 0);
   localparam logic signed [W-1:0] HI  = {{(W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [W-1:0] LO  = ~HI;
   logic signed [W-1:0] sum, shr;
   always_comb begin
      sum    = W'(acc_i) + RND;
      shr    = sum >>> SHIFT;
      sat_o  = shr > HI || shr < LO;
      dout_o = shr > HI ? HI[OUT_W-1:0] : shr < LO ? LO[OUT_W-1:0] : shr[OUT_W-1:0];
   end
endmodule

// File: rtl/fir_mul_pipe.sv
// fir_mul_pipe: pipelined multiply-accumulate with valid/ready flow control, grouped accumulation and round/saturate output
module fir_mul_pipe
   import fir_mul_pkg::*;
#(
   parameter int A_W       = A_W_DEF,
   parameter int B_W       = B_W_DEF,
   parameter int OUT_W     = OUT_W_DEF,
   parameter int NUM_STAGE = NUM_STAGE_DEF,
   parameter int SHIFT     = SHIFT_DEF,
   parameter int GUARD     = GUARD_DEF
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_W-1:0]   din0,
   input  logic [B_W-1:0]   din1,
   input  logic             b_signed,
   input  logic             in_first,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] dout,
   output logic             sat
);
   localparam int P_W   = p_w(A_W, B_W);
   localparam int ACC_W = acc_w(A_W, B_W, GUARD);
   localparam int BW    = A_W + B_W + 4;
   if (!stage_ok(NUM_STAGE)) begin : g_bad_stage
      $error("fir_mul_pipe: NUM_STAGE must be 1..4");
   end
   if (!shift_ok(SHIFT, A_W, B_W)) begin : g_bad_shift
      $error("fir_mul_pipe: SHIFT must be 0..A_W+B_W-1");
   end
   if (GUARD < 0) begin : g_bad_guard
      $error("fir_mul_pipe: GUARD must be non-negative");
   end
   logic                    stall, out_valid_q;
   logic [BW-1:0]           in_beat, head;
   logic                    h_v, h_first, h_last, h_bs;
   logic signed [A_W-1:0]   h_a;
   logic [B_W-1:0]          h_b;
   logic signed [P_W-1:0]   prod;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   assign stall     = out_valid_q & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = out_valid_q;
   assign in_beat   = {in_valid, in_first, in_last, b_signed, din0, din1};
   if (NUM_STAGE == 1) begin : g_comb
      assign head = in_beat;
   end else begin : g_reg
      logic [BW-1:0] pipe_q [NUM_STAGE-1];
      always_ff @(posedge ap_clk)
         if (ap_rst) for (int i = 0; i < NUM_STAGE - 1; i++) pipe_q[i] <= '0;
         else if (!stall) begin
            pipe_q[0] <= in_beat;
            for (int i = 1; i < NUM_STAGE - 1; i++) pipe_q[i] <= pipe_q[i-1];
         end
      assign head = pipe_q[NUM_STAGE-2];
   end
   assign {h_v, h_first, h_last, h_bs, h_a, h_b} = head;
   // din1 widened by one bit so the unsigned case is a positive signed operand
   always_comb begin
      prod  = P_W'(h_a) * P_W'($signed({h_bs & h_b[B_W-1], h_b}));
      acc_d = h_first ? ACC_W'(prod) : acc_q + ACC_W'(prod);
   end
   always_ff @(posedge ap_clk)
      if (ap_rst) begin
         acc_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (!stall) begin
         out_valid_q <= h_v & h_last;
         if (h_v) acc_q <= acc_d;
      end
   fir_mul_round_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_round_sat (
      .acc_i  (acc_q),
      .dout_o (dout),
      .sat_o  (sat)
   );
endmodule

// File: doc/fir_mul_pipe.md
FIR_MUL_PIPE -- requirements
Module: fir_mul_pipe

Interface
REQ-001 SHALL have parameter A_W, default 16, giving the din0 width; din0 is always signed.
REQ-002 SHALL have parameter B_W, default 11, giving the din1 width.
REQ-003 SHALL have parameter OUT_W, default 27, giving the dout width.
REQ-004 SHALL have parameter NUM_STAGE, default 2, legal range 1..4, giving the register stages from input acceptance to dout.
REQ-005 SHALL have parameter SHIFT, default 0, legal range 0..A_W+B_W-1, giving the right-shift applied to the accumulator before output.
REQ-006 SHALL have parameter GUARD, default 4, giving the accumulator guard bits.
REQ-007 SHALL have port ap_clk, input, 1 bit: the single clock; all logic uses its rising edge.
REQ-008 SHALL have port ap_rst, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-011 SHALL have port din0, input, A_W bits: signed multiplicand.
REQ-012 SHALL have port din1, input, B_W bits: multiplier.
REQ-013 SHALL have port b_signed, input, 1 bit: 1 treats din1 as signed; 0 zero-extends din1 as unsigned.
REQ-014 SHALL have ports in_first and in_last, input, 1 bit each: accumulation group delimiters.
REQ-015 SHALL have port out_valid, output, 1 bit: dout is valid.
REQ-016 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts dout.
REQ-017 SHALL have port dout, output, OUT_W bits: signed result.
REQ-018 SHALL have port sat, output, 1 bit: dout was saturated; qualified by out_valid.

Function
REQ-019 SHALL accept a beat when in_valid and in_ready are both 1 in the same cycle.
REQ-020 SHALL define stall = out_valid and not out_ready, and SHALL drive in_ready = not stall combinationally.
REQ-021 SHALL freeze every pipeline register, valid bit and the accumulator while stall is 1.
REQ-022 SHALL form a product of width P_W = A_W+B_W; for b_signed=0 the product is din0 times the zero-extended din1.
REQ-023 SHALL register din0, din1 and b_signed in stages 1..NUM_STAGE-1, and SHALL make stage NUM_STAGE the accumulator/output stage; for NUM_STAGE=1 the multiplier feeds the accumulator combinationally.
REQ-024 SHALL carry in_first, in_last and a valid bit alongside the data in every stage.
REQ-025 SHALL, at the final stage for a valid beat, load acc (width P_W+GUARD, signed) with the sign-extended product when first=1, and otherwise add the product to acc.
REQ-026 SHALL wrap acc modulo 2^(P_W+GUARD) on overflow; no flag is raised for acc wrap.
REQ-027 SHALL compute the output as (acc + 2^(SHIFT-1)) arithmetically shifted right by SHIFT (round half up); for SHIFT=0 no rounding term is added.
REQ-028 SHALL saturate the shifted value to the signed OUT_W range and set sat=1 only when clamping occurred.
REQ-029 SHALL assert out_valid only for beats with last=1; a single-beat group (first=last=1) is a plain multiply.
REQ-030 SHALL give a latency of exactly NUM_STAGE cycles from acceptance of the last beat of a group to out_valid when no stall occurs.
REQ-031 SHALL sustain one beat per cycle while out_ready is held at 1.
REQ-032 SHALL add a beat with first=0 that follows a completed group to the retained acc (undefined-group continuation; not an error).
REQ-033 SHALL hold dout and sat stable while out_valid=1 and out_ready=0.

Reset
REQ-034 SHALL, while ap_rst=1 at a clock edge, clear all stage valid bits, out_valid, dout, sat and acc to 0; in_ready is then 1.
REQ-035 SHALL discard any in-flight beats and any partial group when reset is asserted mid-operation; no output is produced for them after reset.

Structure
REQ-036 SHALL take parameter defaults, the P_W/ACC_W width functions and the legal-range checks from shared package fir_mul_pkg.
REQ-037 SHALL implement rounding and saturation in one combinational sub-module, fir_mul_round_sat, parameterised by ACC_W, SHIFT and OUT_W.
REQ-038 SHALL flag illegal parameter values with elaboration-time assertions.

Verification
REQ-039 SHALL verify defaults with b_signed=0, din0=-32768, din1=2047, first=last=1: dout=-67076096, sat=0, 2 cycles after acceptance.
REQ-040 SHALL verify defaults with b_signed=1, din0=-32768, din1=0x7FF: dout=32768.
REQ-041 SHALL verify a 3-beat group of (100,3), (-50,2), (7,1): exactly one output, dout=207, on the last beat.
REQ-042 SHALL verify that holding out_ready=0 for 5 cycles with a full pipe drops in_ready to 0, holds dout stable, and, after release, delivers all results in order with none lost or duplicated.
REQ-043 SHALL verify OUT_W=16 and SHIFT=0 with din0=32767, din1=2047 unsigned: dout=32767, sat=1.
REQ-044 SHALL verify that asserting ap_rst after beat 2 of a 3-beat group gives no output; a subsequent single-beat (5,5) group then yields dout=25.
